// File: rtl/binary_counter_multimode_if.sv
// rtl/binary_counter_multimode_if.sv - control and status bundle for the multimode counter
//
// Purpose: groups the counter's control inputs and status outputs.
// Modports:
//   master : drives mode/en/key_up/key_down/load/load_value, observes count/tick/limit
//   slave  : the counter side (inputs and outputs swapped)

interface binary_counter_multimode_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       mode;
  logic             en;
  logic             key_up;
  logic             key_down;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             limit;

  modport master (
    output mode, en, key_up, key_down, load, load_value,
    input  count, tick, limit
  );

  modport slave (
    input  mode, en, key_up, key_down, load, load_value,
    output count, tick, limit
  );
endinterface

// File: rtl/binary_counter_multimode.sv
// rtl/binary_counter_multimode.sv - up/down counter stepped by prescaled tick or debounced keys
//
// Purpose: WIDTH-bit up/down counter with a prescaler tick, two debounced key
// inputs, synchronous load and wrap-or-saturate boundary handling.
// Ports:
//   clock      : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   bus.mode   : 00 auto-up, 01 auto-down, 10 key-step, 11 hold
//   bus.en     : counting enable (also gates the prescaler)
//   bus.key_up / bus.key_down : raw asynchronous buttons, active high
//   bus.load / bus.load_value : synchronous load strobe and value
//   bus.count  : registered count
//   bus.tick   : registered one-cycle prescaler pulse
//   bus.limit  : registered one-cycle pulse on wrap or saturation

module binary_counter_multimode #(
  parameter int WIDTH      = 8,
  parameter int TICK_DIV   = 2_700_000,
  parameter int DEB_CYCLES = 270_000,
  parameter bit WRAP       = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  binary_counter_multimode_if.slave   bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]    DEB_LAST   = DW'(DEB_CYCLES);
  localparam logic [WIDTH-1:0] MAXV       = '1;

  // Key vectors: bit 0 is key_up, bit 1 is key_down.
  logic [1:0]          key_raw;
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          stable_q, stable_d;
  logic [1:0]          stable_prev_q;
  logic [1:0][DW-1:0]  deb_q, deb_d;
  logic [1:0]          key_step;

  logic [PW-1:0]       presc_q, presc_d;
  logic                tick_q, tick_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                limit_q, limit_d;
  logic                up_req, dn_req;

  assign key_raw = {bus.key_down, bus.key_up};

  // Prescaler: tick_d is the value tick takes at this edge, so auto-mode
  // steps land on the same edge that registers tick high.
  always_comb begin
    presc_d = '0;
    tick_d  = 1'b0;
    if (bus.en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Debouncers: the counter measures how long the synchronised level has
  // disagreed with the accepted level.
  always_comb begin
    deb_d    = deb_q;
    stable_d = stable_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        deb_d[i] = '0;
      end else if (deb_q[i] == DEB_LAST) begin
        stable_d[i] = sync2_q[i];
        deb_d[i]    = '0;
      end else begin
        deb_d[i] = deb_q[i] + DW'(1);
      end
    end
  end

  // Rising edge of the accepted level only; releases are ignored.
  assign key_step = stable_q & ~stable_prev_q;

  always_comb begin
    up_req = 1'b0;
    dn_req = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        2'b00:   up_req = tick_d;
        2'b01:   dn_req = tick_d;
        2'b10: begin
          up_req = key_step[0];
          dn_req = key_step[1];
        end
        default: ;
      endcase
    end
  end

  // Load beats any step; simultaneous up and down cancel.
  always_comb begin
    count_d = count_q;
    limit_d = 1'b0;
    if (bus.load) begin
      count_d = bus.load_value;
    end else if (up_req && !dn_req) begin
      if (count_q == MAXV) begin
        limit_d = 1'b1;
        if (WRAP) count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (dn_req && !up_req) begin
      if (count_q == '0) begin
        limit_d = 1'b1;
        if (WRAP) count_d = MAXV;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q       <= '0;
      tick_q        <= 1'b0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      deb_q         <= '0;
      count_q       <= '0;
      limit_q       <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      tick_q        <= tick_d;
      sync1_q       <= key_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      deb_q         <= deb_d;
      count_q       <= count_d;
      limit_q       <= limit_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.limit = limit_q;

endmodule

// File: tb/tb_binary_counter_multimode.sv
// tb/tb_binary_counter_multimode.sv - randomized self-checking bench for binary_counter_multimode

module tb_binary_counter_multimode;

  localparam int W    = 4;
  localparam int TD   = 4;
  localparam int DEB  = 3;
  localparam int MAXV = (1 << W) - 1;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   mode       = 2'b00;
  logic         en         = 1'b0;
  logic         key_up     = 1'b0;
  logic         key_down   = 1'b0;
  logic         load       = 1'b0;
  logic [W-1:0] load_value = '0;

  always #5 clock = ~clock;

  binary_counter_multimode_if #(.WIDTH(W)) bw ();
  binary_counter_multimode_if #(.WIDTH(W)) bs ();

  assign bw.mode = mode;  assign bw.en = en;  assign bw.key_up = key_up;
  assign bw.key_down = key_down;  assign bw.load = load;  assign bw.load_value = load_value;
  assign bs.mode = mode;  assign bs.en = en;  assign bs.key_up = key_up;
  assign bs.key_down = key_down;  assign bs.load = load;  assign bs.load_value = load_value;

  binary_counter_multimode #(.WIDTH(W), .TICK_DIV(TD), .DEB_CYCLES(DEB), .WRAP(1'b1)) dut_w (
    .clock(clock), .reset_n(reset_n), .bus(bw)
  );
  binary_counter_multimode #(.WIDTH(W), .TICK_DIV(TD), .DEB_CYCLES(DEB), .WRAP(1'b0)) dut_s (
    .clock(clock), .reset_n(reset_n), .bus(bs)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: tick from the number of consecutive enabled edges,
  // keys accepted after DEB+1 consecutive disagreeing samples.
  int en_run;
  bit mtick;
  int hist [2][2];   // raw samples from the last two edges
  int st   [2];      // accepted level
  int stp  [2];      // accepted level one edge earlier
  int mlen [2];      // consecutive edges of disagreement
  int mc_w, mc_s;
  bit ml_w, ml_s;
  int n_tick, n_lim_w, n_lim_s;

  task automatic model_reset();
    en_run = 0; mtick = 1'b0;
    for (int k = 0; k < 2; k++) begin
      hist[k][0] = 0; hist[k][1] = 0; st[k] = 0; stp[k] = 0; mlen[k] = 0;
    end
    mc_w = 0; mc_s = 0; ml_w = 1'b0; ml_s = 1'b0;
  endtask

  task automatic upd(inout int c, output bit l, input bit wrap, input bit up, input bit dn);
    l = 1'b0;
    if (load) c = int'(load_value);
    else if (up && !dn) begin
      if (c == MAXV) begin l = 1'b1; if (wrap) c = 0; end
      else c = c + 1;
    end else if (dn && !up) begin
      if (c == 0) begin l = 1'b1; if (wrap) c = MAXV; end
      else c = c - 1;
    end
  endtask

  task automatic model_step();
    bit req [2];
    int raw [2];
    int lvl;
    bit up, dn;
    raw[0] = int'(key_up);
    raw[1] = int'(key_down);
    if (en) begin
      en_run++;
      mtick = (en_run % TD) == 0;
    end else begin
      en_run = 0;
      mtick  = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      req[k] = (st[k] == 1) && (stp[k] == 0);
      stp[k] = st[k];
      lvl = hist[k][1];
      if (lvl == st[k]) mlen[k] = 0;
      else begin
        mlen[k]++;
        if (mlen[k] == DEB + 1) begin st[k] = lvl; mlen[k] = 0; end
      end
      hist[k][1] = hist[k][0];
      hist[k][0] = raw[k];
    end
    up = en && ((mode == 2'd0 && mtick) || (mode == 2'd2 && req[0]));
    dn = en && ((mode == 2'd1 && mtick) || (mode == 2'd2 && req[1]));
    upd(mc_w, ml_w, 1'b1, up, dn);
    upd(mc_s, ml_s, 1'b0, up, dn);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    model_step();
    chk("w.count", 32'(bw.count), mc_w);
    chk("w.tick",  32'(bw.tick),  32'(mtick));
    chk("w.limit", 32'(bw.limit), 32'(ml_w));
    chk("s.count", 32'(bs.count), mc_s);
    chk("s.tick",  32'(bs.tick),  32'(mtick));
    chk("s.limit", 32'(bs.limit), 32'(ml_s));
    if (bw.tick)  n_tick++;
    if (bw.limit) n_lim_w++;
    if (bs.limit) n_lim_s++;
  endtask

  // Called just after an edge: asserts reset mid-cycle, checks the outputs
  // cleared without a clock edge, releases on the following negedge.
  task automatic do_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    chk({tag, ".count"}, 32'(bw.count), 0);
    chk({tag, ".tick"},  32'(bw.tick),  0);
    chk({tag, ".limit"}, 32'(bw.limit), 0);
    chk({tag, ".s_count"}, 32'(bs.count), 0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, lat;
    logic [W-1:0] prev;
    model_reset();
    n_tick = 0; n_lim_w = 0; n_lim_s = 0;
    #3;
    chk("rst.count", 32'(bw.count), 0);
    chk("rst.tick",  32'(bw.tick),  0);
    chk("rst.limit", 32'(bw.limit), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // 1: auto-up from reset, 20 ticks in 80 cycles
    mode = 2'd0; en = 1'b1;
    for (int i = 0; i < 80; i++) cyc();
    chk("t1.ticks", n_tick, 20);
    chk("t1.w_limits", n_lim_w, 1);
    chk("t1.s_limits", n_lim_s, 5);
    chk("t1.w_count", 32'(bw.count), 4);

    // 2: auto-down from 0, saturate then load
    do_reset("t2rst");
    mode = 2'd1;
    for (int i = 0; i < 4; i++) cyc();
    chk("t2.s_count", 32'(bs.count), 0);
    chk("t2.s_limit", 32'(bs.limit), 1);
    chk("t2.w_count", 32'(bw.count), 15);
    load = 1'b1; load_value = 4'd5;
    cyc();
    load = 1'b0;
    chk("t2.load", 32'(bs.count), 5);
    for (int i = 0; i < 7; i++) cyc();
    chk("t2.s_final", 32'(bs.count), 3);

    // 3: bouncing key_up, one increment, 6-cycle latency
    mode = 2'd2;
    base = mc_w;
    key_up = 1'b1; cyc(); key_up = 1'b0; cyc();
    key_up = 1'b1; cyc(); key_up = 1'b0; cyc();
    key_up = 1'b1;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      prev = bw.count;
      cyc();
      if (lat < 0 && bw.count != prev) lat = i;
    end
    chk("t3.latency", lat, 6);
    chk("t3.count", 32'(bw.count), (base + 1) % (MAXV + 1));
    key_up = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("t3.release", 32'(bw.count), (base + 1) % (MAXV + 1));

    // 4: both keys together cancel
    base = mc_w; n_lim_w = 0;
    key_up = 1'b1; key_down = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    key_up = 1'b0; key_down = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("t4.count", 32'(bw.count), base);
    chk("t4.limits", n_lim_w, 0);

    // 5: load beats a tick-driven wrap
    mode = 2'd0;
    load = 1'b1; load_value = 4'd15;
    cyc();
    load = 1'b0;
    while (((en_run + 1) % TD) != 0) cyc();
    load = 1'b1; load_value = 4'd9;
    cyc();
    load = 1'b0;
    chk("t5.count", 32'(bw.count), 9);
    chk("t5.limit", 32'(bw.limit), 0);
    chk("t5.tick",  32'(bw.tick),  1);

    // 6: asynchronous reset at count 7, then first tick 4 cycles later
    load = 1'b1; load_value = 4'd7;
    cyc();
    load = 1'b0;
    chk("t6.pre", 32'(bw.count), 7);
    do_reset("t6rst");
    for (int i = 0; i < 4; i++) cyc();
    chk("t6.tick",  32'(bw.tick),  1);
    chk("t6.count", 32'(bw.count), 1);

    // Random phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(31) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(63) == 0) en = ~en;
      if ($urandom_range(7) == 0) key_up = ~key_up;
      if ($urandom_range(7) == 0) key_down = ~key_down;
      load = ($urandom_range(39) == 0);
      load_value = 4'($urandom_range(15));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_counter_multimode.md
# binary_counter_multimode

Parametrised successor to the free-running LED binary counter. It runs an up/down counter of configurable width, stepped either by an internal prescaled tick or by debounced key presses, with synchronous load and wrap-or-saturate boundary handling. It sits between the board key inputs and the LED/7-segment drivers in the hackathon top level. `count` drives `led` directly.

## Interface
- `WIDTH`, 8: counter width in bits, range 2..32.
- `TICK_DIV`, 2_700_000: clock cycles per tick, giving 10 Hz at 27 MHz. Minimum 2.
- `DEB_CYCLES`, 270_000: consecutive stable cycles needed to accept a key level change, 10 ms at 27 MHz. Minimum 1.
- `WRAP`, 1: 1 wraps at the boundaries; 0 saturates.

Ports:
- `clock`, in, 1: the single clock. All logic is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `mode`, in, 2: 00 auto-up, 01 auto-down, 10 key-step, 11 hold.
- `en`, in, 1: counting enable.
- `key_up`, in, 1: raw asynchronous button, active high.
- `key_down`, in, 1: raw asynchronous button, active high.
- `load`, in, 1: synchronous load strobe.
- `load_value`, in, WIDTH: value captured on `load`.
- `count`, out, WIDTH: current count, registered.
- `tick`, out, 1: one-cycle prescaler pulse, registered.
- `limit`, out, 1: one-cycle pulse when a step hits a boundary, registered.

## Operation
Reset (`reset_n` = 0):
- `count`, `tick`, `limit`, prescaler, debounce counters, synchronisers and stable key states all go to 0 immediately.

Prescaler:
- Counts 0..TICK_DIV-1 while `en` = 1.
- `tick` = 1 for the cycle after the prescaler reaches TICK_DIV-1; the prescaler then returns to 0.
- While `en` = 0, the prescaler is held at 0 and `tick` = 0.
- The prescaler runs in every mode.

Key path (one instance per key):
- 2-flop synchroniser, then a debouncer.
- Debounce counter clears whenever the synchronised level equals the stable level. Otherwise it increments.
- When the counter reaches DEB_CYCLES, the stable level takes the synchronised level and the counter clears.
- A 0→1 transition of the stable level produces a one-cycle step request.
- 1→0 transitions produce nothing.
- Debouncers run regardless of `en` and `mode`.

Step selection, evaluated each cycle:
- Mode 00: a step-up request when `tick` = 1.
- Mode 01: a step-down request when `tick` = 1.
- Mode 10: up request = `key_up` step, down request = `key_down` step. `tick` is ignored.
- Mode 11: no requests.
- `en` = 0: all requests are discarded, including key steps.
- Up and down requested in the same cycle: they cancel. No change, no `limit`.

Count update, in priority order:
1. `load` = 1 (ignores `en` and `mode`): `count` ← `load_value`, `limit` = 0, and any simultaneous step is discarded.
2. Up request:
   - Below max: `count` + 1.
   - At max with WRAP = 1: `count` becomes 0 and `limit` = 1.
   - At max with WRAP = 0: `count` is held and `limit` = 1.
3. Down request:
   - Above 0: `count` − 1.
   - At 0 with WRAP = 1: `count` becomes max and `limit` = 1.
   - At 0 with WRAP = 0: `count` is held and `limit` = 1.

Mode changes:
- Take effect on the first edge where the new `mode` is sampled.
- The prescaler phase is not disturbed.

Arithmetic:
- Unsigned, modulo 2^WIDTH.
- max = 2^WIDTH − 1.

## Timing
- `tick` rises TICK_DIV cycles after `en` rises from a reset or disabled state. It then repeats with period exactly TICK_DIV.
- Auto modes: `count` changes on the same edge that `tick` is registered high, so both are visible in the same cycle.
- Key-step latency: a clean press is sampled at edge N. `count` changes at edge N + 2 (sync) + DEB_CYCLES + 1.
- Glitches shorter than DEB_CYCLES cycles never change the stable level.
- `load`: sampled at edge N, `count` = `load_value` after edge N.
- `limit`: high for exactly one cycle, aligned with the update that wrapped or saturated.
- Reset asserted mid-operation clears everything asynchronously.
- After reset deasserts, the first tick arrives TICK_DIV cycles later.

## Test plan
Bench parameters: WIDTH = 4, TICK_DIV = 4, DEB_CYCLES = 3 unless noted.

1. Reset low, then high; mode 00, `en` = 1; run 80 cycles. Expect `tick` every 4th cycle and `count` 0,1,…,15,0. `limit` pulses exactly once, on the 15→0 update.
2. WRAP = 0, mode 01, start from 0. First tick: `count` stays 0 and `limit` = 1 for 1 cycle. Then `load` 5 → `count` = 5, followed by 4, 3 on subsequent ticks.
3. Mode 10; `key_up` bounces 1-0-1-0 at 1-cycle intervals, then held high for 10 cycles. Expect exactly one increment. Latency from stable high to `count` change = 6 cycles.
4. Mode 10; `key_up` and `key_down` pressed on the same cycle, both clean. Expect no `count` change and no `limit`.
5. `load` = 1 with `load_value` = 9 in the same cycle as a tick-driven up step. Expect `count` = 9 and `limit` = 0.
6. Count at 7, mode 00. Pull `reset_n` low mid-cycle. Expect `count`, `tick`, `limit` = 0 immediately. After release, first `tick` is 4 cycles later and `count` = 1.
